// File: rtl/folded_history_reg.sv
// Global branch history register with an XOR-folded copy for TAGE-style indexing.
// The fold is updated incrementally per outcome and rebuilt serially after a restore.
module folded_history_reg #(
  parameter int INPUT_LENGTH  = 10,
  parameter int OUTPUT_LENGTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     update_valid_i,
  input  logic                     update_taken_i,
  output logic                     update_ready_o,
  input  logic                     restore_valid_i,
  input  logic [INPUT_LENGTH-1:0]  restore_ghr_i,
  output logic [INPUT_LENGTH-1:0]  ghr_o,
  output logic [OUTPUT_LENGTH-1:0] folded_o,
  output logic                     folded_valid_o
);

  localparam int NUM_CHUNKS = (INPUT_LENGTH + OUTPUT_LENGTH - 1) / OUTPUT_LENGTH;
  localparam int PAD_LENGTH = NUM_CHUNKS * OUTPUT_LENGTH;
  localparam int DROP_POS   = INPUT_LENGTH % OUTPUT_LENGTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic {READY, REBUILD} state_t;

  state_t                   state;
  logic [INPUT_LENGTH-1:0]  ghr;
  logic [OUTPUT_LENGTH-1:0] folded;
  logic [OUTPUT_LENGTH-1:0] acc;
  logic                     folded_valid;
  logic [IDX_W-1:0]         idx;

  logic [PAD_LENGTH-1:0]    ghr_pad;
  logic [OUTPUT_LENGTH-1:0] chunk;
  logic [OUTPUT_LENGTH-1:0] folded_shift;

  assign ghr_pad = PAD_LENGTH'(ghr);
  assign chunk   = ghr_pad[idx*OUTPUT_LENGTH +: OUTPUT_LENGTH];

  // Shifting the GHR left rotates every folded bit by one; the incoming outcome
  // lands on bit 0 and the dropped MSB would have wrapped to INPUT_LENGTH % OUTPUT_LENGTH.
  assign folded_shift = {folded[OUTPUT_LENGTH-2:0], folded[OUTPUT_LENGTH-1]}
                      ^ OUTPUT_LENGTH'(update_taken_i)
                      ^ (OUTPUT_LENGTH'(ghr[INPUT_LENGTH-1]) << DROP_POS);

  assign update_ready_o = (state == READY) && !restore_valid_i;
  assign ghr_o          = ghr;
  assign folded_o       = folded;
  assign folded_valid_o = folded_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= READY;
      ghr          <= '0;
      folded       <= '0;
      folded_valid <= 1'b1;
      acc          <= '0;
      idx          <= '0;
    end else if (restore_valid_i) begin
      state        <= REBUILD;
      ghr          <= restore_ghr_i;
      folded_valid <= 1'b0;
      acc          <= '0;
      idx          <= '0;
    end else begin
      case (state)
        READY: begin
          if (update_valid_i) begin
            ghr    <= {ghr[INPUT_LENGTH-2:0], update_taken_i};
            folded <= folded_shift;
          end
        end
        REBUILD: begin
          acc <= acc ^ chunk;
          if (idx == IDX_W'(NUM_CHUNKS - 1)) begin
            folded       <= acc ^ chunk;
            folded_valid <= 1'b1;
            state        <= READY;
            idx          <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: tb/tb_folded_history_reg.sv
// Bench for folded_history_reg: directed scenarios on a 10/8 instance plus
// randomized traffic on 10/8, 16/8 and 23/7 instances against a fold model.
module tb_folded_history_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_taken = 1'b0;
  logic        rs_valid = 1'b0;
  logic [22:0] rs_ghr = '0;

  logic        rdy0, fv0, rdy1, fv1, rdy2, fv2;
  logic [9:0]  ghr0;
  logic [15:0] ghr1;
  logic [22:0] ghr2;
  logic [7:0]  fold0, fold1;
  logic [6:0]  fold2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  folded_history_reg #(.INPUT_LENGTH(10), .OUTPUT_LENGTH(8)) dut0 (
    .clk(clk), .rst(rst), .update_valid_i(upd_valid), .update_taken_i(upd_taken),
    .update_ready_o(rdy0), .restore_valid_i(rs_valid), .restore_ghr_i(rs_ghr[9:0]),
    .ghr_o(ghr0), .folded_o(fold0), .folded_valid_o(fv0));

  folded_history_reg #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(8)) dut1 (
    .clk(clk), .rst(rst), .update_valid_i(upd_valid), .update_taken_i(upd_taken),
    .update_ready_o(rdy1), .restore_valid_i(rs_valid), .restore_ghr_i(rs_ghr[15:0]),
    .ghr_o(ghr1), .folded_o(fold1), .folded_valid_o(fv1));

  folded_history_reg #(.INPUT_LENGTH(23), .OUTPUT_LENGTH(7)) dut2 (
    .clk(clk), .rst(rst), .update_valid_i(upd_valid), .update_taken_i(upd_taken),
    .update_ready_o(rdy2), .restore_valid_i(rs_valid), .restore_ghr_i(rs_ghr[22:0]),
    .ghr_o(ghr2), .folded_o(fold2), .folded_valid_o(fv2));

  // Reference fold: every history bit i contributes to folded bit i mod O.
  function automatic longint unsigned fold_ref(input longint unsigned g, input int len, input int ow);
    longint unsigned r = 0;
    for (int i = 0; i < len; i++)
      if (g[i]) r[i % ow] = ~r[i % ow];
    return r;
  endfunction

  function automatic longint unsigned obs_ghr(input int k);
    case (k)
      0: return 64'(ghr0);
      1: return 64'(ghr1);
      default: return 64'(ghr2);
    endcase
  endfunction

  function automatic longint unsigned obs_fold(input int k);
    case (k)
      0: return 64'(fold0);
      1: return 64'(fold1);
      default: return 64'(fold2);
    endcase
  endfunction

  function automatic logic obs_valid(input int k);
    case (k)
      0: return fv0;
      1: return fv1;
      default: return fv2;
    endcase
  endfunction

  function automatic logic obs_ready(input int k);
    case (k)
      0: return rdy0;
      1: return rdy1;
      default: return rdy2;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; upd_valid = 1'b0; rs_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ghr0 !== 10'h000) begin n_bad++; $display("FAIL reset_ghr: got %h want 000", ghr0); end
    n_cmp++; if (fold0 !== 8'h00) begin n_bad++; $display("FAIL reset_fold: got %h want 00", fold0); end
    n_cmp++; if (fv0 !== 1'b1) begin n_bad++; $display("FAIL reset_valid: got %b want 1", fv0); end
    n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", rdy0); end
  endtask

  task automatic test_update_basic();
    do_reset();
    upd_valid = 1'b1; upd_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b want 1", rdy0); end
      tick();
      n_cmp++; if (fv0 !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", fv0); end
    end
    upd_valid = 1'b0;
    n_cmp++; if (ghr0 !== 10'h003) begin n_bad++; $display("FAIL basic_ghr: got %h want 003", ghr0); end
    n_cmp++; if (fold0 !== 8'h03) begin n_bad++; $display("FAIL basic_fold: got %h want 03", fold0); end
  endtask

  task automatic test_saturate();
    do_reset();
    upd_valid = 1'b1; upd_taken = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++; if (ghr0 !== 10'h3FF) begin n_bad++; $display("FAIL sat_ghr10: got %h want 3ff", ghr0); end
    n_cmp++; if (fold0 !== 8'hFC) begin n_bad++; $display("FAIL sat_fold10: got %h want fc", fold0); end
    tick();
    upd_valid = 1'b0;
    n_cmp++; if (ghr0 !== 10'h3FF) begin n_bad++; $display("FAIL sat_ghr11: got %h want 3ff", ghr0); end
    n_cmp++; if (fold0 !== 8'hFC) begin n_bad++; $display("FAIL sat_fold11: got %h want fc", fold0); end
  endtask

  task automatic test_restore();
    do_reset();
    rs_valid = 1'b1; rs_ghr = 23'h0002A5;
    tick();
    rs_valid = 1'b0;
    n_cmp++; if (ghr0 !== 10'h2A5) begin n_bad++; $display("FAIL rst_ghr: got %h want 2a5", ghr0); end
    n_cmp++; if (fv0 !== 1'b0) begin n_bad++; $display("FAIL rst_valid_c1: got %b want 0", fv0); end
    tick();
    n_cmp++; if (fv0 !== 1'b0) begin n_bad++; $display("FAIL rst_valid_c2: got %b want 0", fv0); end
    tick();
    n_cmp++; if (fv0 !== 1'b1) begin n_bad++; $display("FAIL rst_valid_c3: got %b want 1", fv0); end
    n_cmp++; if (fold0 !== 8'hA7) begin n_bad++; $display("FAIL rst_fold: got %h want a7", fold0); end
  endtask

  task automatic test_update_blocked();
    do_reset();
    upd_valid = 1'b1; upd_taken = 1'b1;
    rs_valid = 1'b1; rs_ghr = 23'h0002A5;
    #1;
    n_cmp++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL blk_ready_rs: got %b want 0", rdy0); end
    tick();
    rs_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL blk_ready_rb: got %b want 0", rdy0); end
      n_cmp++; if (ghr0 !== 10'h2A5) begin n_bad++; $display("FAIL blk_ghr_hold: got %h want 2a5", ghr0); end
      tick();
    end
    n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL blk_ready_back: got %b want 1", rdy0); end
    n_cmp++; if (ghr0 !== 10'h2A5) begin n_bad++; $display("FAIL blk_ghr_pre: got %h want 2a5", ghr0); end
    tick();
    upd_valid = 1'b0;
    n_cmp++; if (ghr0 !== 10'h14B) begin n_bad++; $display("FAIL blk_ghr: got %h want 14b", ghr0); end
    n_cmp++; if (fold0 !== 8'h4A) begin n_bad++; $display("FAIL blk_fold: got %h want 4a", fold0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rs_valid = 1'b1; rs_ghr = 23'h0002A5;
    tick();
    rs_ghr = 23'h0000FF;
    tick();
    rs_valid = 1'b0;
    n_cmp++; if (ghr0 !== 10'h0FF) begin n_bad++; $display("FAIL b2b_ghr: got %h want 0ff", ghr0); end
    n_cmp++; if (fv0 !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_c1: got %b want 0", fv0); end
    tick();
    n_cmp++; if (fv0 !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_c2: got %b want 0", fv0); end
    tick();
    n_cmp++; if (fv0 !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_c3: got %b want 1", fv0); end
    n_cmp++; if (fold0 !== 8'hFF) begin n_bad++; $display("FAIL b2b_fold: got %h want ff", fold0); end
    rs_valid = 1'b1; rs_ghr = 23'h0002A5;
    tick();
    rs_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (ghr0 !== 10'h000) begin n_bad++; $display("FAIL midrst_ghr: got %h want 000", ghr0); end
    n_cmp++; if (fold0 !== 8'h00) begin n_bad++; $display("FAIL midrst_fold: got %h want 00", fold0); end
    n_cmp++; if (fv0 !== 1'b1) begin n_bad++; $display("FAIL midrst_valid: got %b want 1", fv0); end
  endtask

  task automatic test_random(input int cycles);
    int lens[3] = '{10, 16, 23};
    int outs[3] = '{8, 8, 7};
    longint unsigned m_ghr[3];
    int m_busy[3];
    logic exp_rdy;
    longint unsigned mask, exp_fold;
    do_reset();
    for (int k = 0; k < 3; k++) begin m_ghr[k] = 0; m_busy[k] = 0; end
    for (int c = 0; c < cycles; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      rs_valid  = !rst && ($urandom_range(0, 14) == 0);
      upd_valid = $urandom_range(0, 1) == 1;
      upd_taken = $urandom_range(0, 1) == 1;
      rs_ghr    = 23'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        exp_rdy = (m_busy[k] == 0) && !rs_valid;
        n_cmp++;
        if (obs_ready(k) !== exp_rdy) begin
          n_bad++;
          $display("FAIL rnd_ready[%0d] cyc %0d: got %b want %b", k, c, obs_ready(k), exp_rdy);
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        mask = (64'd1 << lens[k]) - 1;
        if (rst) begin
          m_ghr[k] = 0; m_busy[k] = 0;
        end else if (rs_valid) begin
          m_ghr[k] = 64'(rs_ghr) & mask;
          m_busy[k] = (lens[k] + outs[k] - 1) / outs[k];
        end else if (m_busy[k] > 0) begin
          m_busy[k]--;
        end else if (upd_valid) begin
          m_ghr[k] = ((m_ghr[k] << 1) | 64'(upd_taken)) & mask;
        end
        n_cmp++;
        if (obs_ghr(k) !== m_ghr[k]) begin
          n_bad++;
          $display("FAIL rnd_ghr[%0d] cyc %0d: got %h want %h", k, c, obs_ghr(k), m_ghr[k]);
        end
        n_cmp++;
        if (obs_valid(k) !== (m_busy[k] == 0)) begin
          n_bad++;
          $display("FAIL rnd_valid[%0d] cyc %0d: got %b want %b", k, c, obs_valid(k), m_busy[k] == 0);
        end
        if (m_busy[k] == 0) begin
          exp_fold = fold_ref(m_ghr[k], lens[k], outs[k]);
          n_cmp++;
          if (obs_fold(k) !== exp_fold) begin
            n_bad++;
            $display("FAIL rnd_fold[%0d] cyc %0d: got %h want %h", k, c, obs_fold(k), exp_fold);
          end
        end
      end
    end
    rst = 1'b0; rs_valid = 1'b0; upd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_update_basic();
    test_saturate();
    test_restore();
    test_update_blocked();
    test_back_to_back();
    test_random(5000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
